// File: rtl/reorder_buffer_pkg.sv
// Shared tag geometry and redirect helper for the reorder buffer.
package reorder_buffer_pkg;

  localparam int TAG_W     = 5;
  localparam int DEPTH_MAX = 31;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t TAG_NONE = '0;

  function automatic logic [31:0] redirect_pc(input logic        taken,
                                              input logic [31:0] target,
                                              input logic [31:0] pc);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular ROB: allocates tags, captures CDB results, retires in order; commit outputs registered (1 cycle).
// Dispatch stalls while full or flushing; rdy low freezes every register including output pulses.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic [TAG_W-1:0] dispatch_rd,
  input  logic             dispatch_is_branch,
  input  logic             dispatch_is_store,
  input  logic [31:0]      dispatch_pc,
  input  logic             dispatch_pred_taken,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_target,
  input  logic [TAG_W-1:0] query_tag1,
  input  logic [TAG_W-1:0] query_tag2,
  output logic             query_ready1,
  output logic             query_ready2,
  output logic [31:0]      query_data1,
  output logic [31:0]      query_data2,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_data,
  output logic             commit_store,
  output logic             wrong_commit,
  output logic [31:0]      flush_pc
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH_MAX + 1);
  typedef logic [IDX_W-1:0] idx_t;

  logic             busy       [DEPTH];
  logic             ready      [DEPTH];
  logic [TAG_W-1:0] rd         [DEPTH];
  logic [31:0]      data       [DEPTH];
  logic [31:0]      pc         [DEPTH];
  logic             is_branch  [DEPTH];
  logic             is_store   [DEPTH];
  logic             pred_taken [DEPTH];
  logic             taken      [DEPTH];
  logic [31:0]      target     [DEPTH];

  idx_t             head, tail;
  logic [CNT_W-1:0] count;

  logic dispatch_fire, commit_fire, cdb_hit, mispredict;
  idx_t cdb_idx, q1_idx, q2_idx;

  function automatic idx_t bump(input idx_t p);
    return (p == idx_t'(DEPTH - 1)) ? '0 : p + idx_t'(1);
  endfunction

  function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
    return (t != TAG_NONE) && (t <= TAG_W'(DEPTH));
  endfunction

  function automatic idx_t tag_idx(input logic [TAG_W-1:0] t);
    return idx_t'(t - TAG_W'(1));
  endfunction

  // head == tail is ambiguous (empty or full); count settles it
  assign dispatch_ready = (count < CNT_W'(DEPTH)) && !wrong_commit;
  assign dispatch_tag   = TAG_W'(tail) + TAG_W'(1);
  assign dispatch_fire  = rdy && dispatch_valid && dispatch_ready;
  assign commit_fire    = rdy && !wrong_commit && busy[head] && ready[head];
  assign mispredict     = commit_fire && is_branch[head] && (taken[head] != pred_taken[head]);
  assign cdb_idx        = tag_idx(cdb_tag);
  assign cdb_hit        = rdy && !wrong_commit && cdb_valid && tag_in_range(cdb_tag) && busy[cdb_idx];
  assign q1_idx         = tag_idx(query_tag1);
  assign q2_idx         = tag_idx(query_tag2);

  always_comb begin
    query_ready1 = 1'b1;
    query_data1  = '0;
    if (query_tag1 != TAG_NONE) begin
      query_ready1 = 1'b0;
      if (tag_in_range(query_tag1) && busy[q1_idx] && ready[q1_idx]) begin
        query_ready1 = 1'b1;
        query_data1  = data[q1_idx];
      end else if (cdb_valid && cdb_tag == query_tag1) begin
        query_ready1 = 1'b1;
        query_data1  = cdb_data;
      end
    end
  end

  always_comb begin
    query_ready2 = 1'b1;
    query_data2  = '0;
    if (query_tag2 != TAG_NONE) begin
      query_ready2 = 1'b0;
      if (tag_in_range(query_tag2) && busy[q2_idx] && ready[q2_idx]) begin
        query_ready2 = 1'b1;
        query_data2  = data[q2_idx];
      end else if (cdb_valid && cdb_tag == query_tag2) begin
        query_ready2 = 1'b1;
        query_data2  = cdb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i]  <= 1'b0;
        ready[i] <= 1'b0;
      end
    end else if (rdy) begin
      if (wrong_commit) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) busy[i] <= 1'b0;
      end else begin
        if (dispatch_fire) begin
          busy[tail]       <= 1'b1;
          ready[tail]      <= 1'b0;
          rd[tail]         <= dispatch_rd;
          pc[tail]         <= dispatch_pc;
          is_branch[tail]  <= dispatch_is_branch;
          is_store[tail]   <= dispatch_is_store;
          pred_taken[tail] <= dispatch_pred_taken;
          tail             <= bump(tail);
        end
        if (cdb_hit) begin
          ready[cdb_idx]  <= 1'b1;
          data[cdb_idx]   <= cdb_data;
          taken[cdb_idx]  <= cdb_taken;
          target[cdb_idx] <= cdb_target;
        end
        if (commit_fire) begin
          busy[head] <= 1'b0;
          head       <= bump(head);
        end
        count <= count + CNT_W'(dispatch_fire) - CNT_W'(commit_fire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      wrong_commit <= 1'b0;
      commit_rd    <= '0;
      commit_tag   <= '0;
      commit_data  <= '0;
      flush_pc     <= '0;
    end else if (rdy) begin
      commit_valid <= commit_fire;
      commit_store <= commit_fire && is_store[head];
      wrong_commit <= mispredict;
      if (commit_fire) begin
        commit_rd   <= rd[head];
        commit_tag  <= TAG_W'(head) + TAG_W'(1);
        commit_data <= data[head];
      end
      if (mispredict) flush_pc <= redirect_pc(taken[head], target[head], pc[head]);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: queue-based program-order model checked every cycle, plus directed literal cases.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst, rdy;
  logic dispatch_valid, dispatch_ready, dispatch_is_branch, dispatch_is_store, dispatch_pred_taken;
  logic [4:0] dispatch_tag, dispatch_rd, cdb_tag, query_tag1, query_tag2, commit_rd, commit_tag;
  logic [31:0] dispatch_pc, cdb_data, cdb_target, query_data1, query_data2, commit_data, flush_pc;
  logic cdb_valid, cdb_taken, query_ready1, query_ready2, commit_valid, commit_store, wrong_commit;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_tag(dispatch_tag),
    .dispatch_rd(dispatch_rd), .dispatch_is_branch(dispatch_is_branch), .dispatch_is_store(dispatch_is_store),
    .dispatch_pc(dispatch_pc), .dispatch_pred_taken(dispatch_pred_taken),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .query_tag1(query_tag1), .query_tag2(query_tag2), .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_data1(query_data1), .query_data2(query_data2),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_data(commit_data),
    .commit_store(commit_store), .wrong_commit(wrong_commit), .flush_pc(flush_pc)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-flight instructions in program order, each carrying its own tag.
  typedef struct {
    logic [4:0]  tag, rd;
    logic [31:0] pc, data, target;
    logic        br, st, pred, done, taken;
  } ent_t;

  ent_t        q[$];
  ent_t        h, n;
  logic [4:0]  m_next = 5'd1;
  logic        e_cv = 1'b0, e_cs = 1'b0, e_wc = 1'b0;
  logic [4:0]  e_rd = '0, e_tag = '0;
  logic [31:0] e_data = '0, e_fpc = '0;
  bit          m_fire, m_disp;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_next = 5'd1;
      e_cv = 0; e_cs = 0; e_wc = 0; e_rd = 0; e_tag = 0; e_data = 0; e_fpc = 0;
    end else if (rdy) begin
      if (e_wc) begin
        q.delete();
        m_next = 5'd1;
        e_cv = 0; e_cs = 0; e_wc = 0;
      end else begin
        m_fire = 0;
        if (q.size() > 0) m_fire = q[0].done;
        m_disp = dispatch_valid && (q.size() < DEPTH);
        e_cv = m_fire; e_cs = 0; e_wc = 0;
        if (m_fire) begin
          h = q[0];
          e_cs = h.st;
          e_wc = h.br && (h.taken != h.pred);
          e_rd = h.rd; e_tag = h.tag; e_data = h.data;
          if (e_wc) e_fpc = h.taken ? h.target : h.pc + 32'd4;
          void'(q.pop_front());
        end
        if (cdb_valid)
          foreach (q[i])
            if (q[i].tag == cdb_tag) begin
              q[i].done = 1; q[i].data = cdb_data; q[i].taken = cdb_taken; q[i].target = cdb_target;
            end
        if (m_disp) begin
          n.tag = m_next; n.rd = dispatch_rd; n.pc = dispatch_pc; n.data = 0; n.target = 0;
          n.br = dispatch_is_branch; n.st = dispatch_is_store; n.pred = dispatch_pred_taken;
          n.done = 0; n.taken = 0;
          q.push_back(n);
          m_next = (m_next == 5'(DEPTH)) ? 5'd1 : m_next + 5'd1;
        end
      end
    end
  end

  function automatic void exp_query(input logic [4:0] t, output logic r, output logic [31:0] d);
    r = 0; d = 0;
    if (t == 0) begin r = 1; return; end
    foreach (q[i]) if (q[i].tag == t && q[i].done) begin r = 1; d = q[i].data; return; end
    if (cdb_valid && cdb_tag == t) begin r = 1; d = cdb_data; end
  endfunction

  always @(negedge clk) begin
    logic qr;
    logic [31:0] qd;
    #2;
    if (chk_en) begin
      check("dispatch_ready", 32'(dispatch_ready), 32'((q.size() < DEPTH) && !e_wc));
      check("dispatch_tag", 32'(dispatch_tag), 32'(m_next));
      check("commit_valid", 32'(commit_valid), 32'(e_cv));
      check("commit_store", 32'(commit_store), 32'(e_cs));
      check("wrong_commit", 32'(wrong_commit), 32'(e_wc));
      check("commit_rd", 32'(commit_rd), 32'(e_rd));
      check("commit_tag", 32'(commit_tag), 32'(e_tag));
      check("commit_data", commit_data, e_data);
      check("flush_pc", flush_pc, e_fpc);
      exp_query(query_tag1, qr, qd);
      check("query_ready1", 32'(query_ready1), 32'(qr));
      if (qr) check("query_data1", query_data1, qd);
      exp_query(query_tag2, qr, qd);
      check("query_ready2", 32'(query_ready2), 32'(qr));
      if (qr) check("query_data2", query_data2, qd);
    end
  end

  task automatic idle();
    rdy = 1; dispatch_valid = 0; dispatch_rd = 0; dispatch_is_branch = 0; dispatch_is_store = 0;
    dispatch_pc = 0; dispatch_pred_taken = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    cdb_taken = 0; cdb_target = 0; query_tag1 = 0; query_tag2 = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic disp(input logic [4:0] r, input logic [31:0] p, input logic br, input logic st, input logic pred);
    dispatch_valid = 1; dispatch_rd = r; dispatch_pc = p;
    dispatch_is_branch = br; dispatch_is_store = st; dispatch_pred_taken = pred;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] d, input logic tk, input logic [31:0] tg);
    cdb_valid = 1; cdb_tag = t; cdb_data = d; cdb_taken = tk; cdb_target = tg;
  endtask

  task automatic do_reset();
    nxt(); rst = 1;
    nxt(); nxt(); rst = 0;
  endtask

  task automatic mispredict_case(input logic pred, input logic tk, input logic [31:0] p,
                                 input logic [31:0] tgt, input logic [31:0] exp_pc);
    do_reset();
    disp(5'd0, p, 1, 0, pred); nxt();
    for (int i = 0; i < 3; i++) begin
      disp(5'(i + 1), p + 32'(4 * (i + 1)), 0, 0, 0); nxt();
    end
    cdb(5'd1, 32'h0, tk, tgt); nxt();
    cdb(5'd2, 32'h55, 0, 0); nxt();
    cdb(5'd3, 32'h66, 0, 0); #1;
    check("mis_wrong_commit", 32'(wrong_commit), 32'd1);
    check("mis_flush_pc", flush_pc, exp_pc);
    check("mis_commit_tag", 32'(commit_tag), 32'd1);
    check("mis_dispatch_ready", 32'(dispatch_ready), 32'd0);
    nxt(); #1;
    check("mis_pulse_end", 32'(wrong_commit), 32'd0);
    check("mis_no_commit", 32'(commit_valid), 32'd0);
    check("mis_tag_reset", 32'(dispatch_tag), 32'd1);
    check("mis_model_empty", 32'(q.size()), 32'd0);
    repeat (2) begin
      nxt(); #1;
      check("mis_young_never_commit", 32'(commit_valid), 32'd0);
    end
  endtask

  initial begin
    idle(); rst = 1;
    do_reset(); chk_en = 1; #1;
    check("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("rst_dispatch_tag", 32'(dispatch_tag), 32'd1);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_wrong_commit", 32'(wrong_commit), 32'd0);

    // in-order retirement with results arriving out of order
    disp(5'd5, 32'h1000, 0, 0, 0); nxt();
    disp(5'd6, 32'h1004, 0, 0, 0); nxt();
    cdb(5'd2, 32'h22, 0, 0); nxt();
    cdb(5'd1, 32'h11, 0, 0); nxt(); #1;
    check("ino_not_early", 32'(commit_valid), 32'd0);
    nxt(); #1;
    check("ino_c1_valid", 32'(commit_valid), 32'd1);
    check("ino_c1_rd", 32'(commit_rd), 32'd5);
    check("ino_c1_data", commit_data, 32'h11);
    nxt(); #1;
    check("ino_c2_tag", 32'(commit_tag), 32'd2);
    check("ino_c2_rd", 32'(commit_rd), 32'd6);
    check("ino_c2_data", commit_data, 32'h22);
    nxt(); #1;
    check("ino_done", 32'(commit_valid), 32'd0);

    // full buffer and wrap-around
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'(i + 1), 32'h2000 + 32'(4 * i), 0, 0, 0); nxt();
    end
    #1;
    check("full_not_ready", 32'(dispatch_ready), 32'd0);
    check("full_tag_wrapped", 32'(dispatch_tag), 32'd1);
    disp(5'd9, 32'h2100, 0, 0, 0); nxt();
    cdb(5'd1, 32'h1234, 0, 0); nxt(); #1;
    check("full_same_cycle", 32'(dispatch_ready), 32'd0);
    nxt(); #1;
    check("wrap_ready", 32'(dispatch_ready), 32'd1);
    check("wrap_tag", 32'(dispatch_tag), 32'd1);
    check("wrap_commit_data", commit_data, 32'h1234);
    disp(5'd7, 32'h2200, 0, 0, 0); nxt(); #1;
    check("wrap_refull", 32'(dispatch_ready), 32'd0);
    check("wrap_next_tag", 32'(dispatch_tag), 32'd2);

    mispredict_case(1'b0, 1'b1, 32'h100, 32'h200, 32'h200);
    mispredict_case(1'b1, 1'b0, 32'h100, 32'h200, 32'h104);

    // query bypass
    do_reset();
    for (int i = 0; i < 3; i++) begin
      disp(5'(i + 1), 32'h400 + 32'(4 * i), 0, 0, 0); nxt();
    end
    query_tag1 = 5'd3; query_tag2 = 5'd0; cdb(5'd3, 32'hABCD, 0, 0); #1;
    check("byp_ready1", 32'(query_ready1), 32'd1);
    check("byp_data1", query_data1, 32'hABCD);
    check("byp_ready2_tag0", 32'(query_ready2), 32'd1);
    check("byp_data2_tag0", query_data2, 32'h0);
    nxt(); query_tag1 = 5'd3; query_tag2 = 5'd2; #1;
    check("qry_stored_data", query_data1, 32'hABCD);
    check("qry_pending", 32'(query_ready2), 32'd0);

    // stall and store
    do_reset();
    disp(5'd0, 32'h3000, 0, 1, 0); nxt();
    cdb(5'd1, 32'h77, 0, 0); nxt();
    for (int i = 0; i < 3; i++) begin
      rdy = 0; #1;
      check("stall_no_commit", 32'(commit_valid), 32'd0);
      check("stall_tag_hold", 32'(dispatch_tag), 32'd2);
      nxt();
    end
    #1;
    check("stall_still_none", 32'(commit_valid), 32'd0);
    nxt(); rdy = 0; #1;
    check("store_pulse", 32'(commit_store), 32'd1);
    check("store_rd", 32'(commit_rd), 32'd0);
    nxt(); rdy = 0; #1;
    check("store_pulse_held", 32'(commit_store), 32'd1);
    nxt(); #1;
    check("store_pulse_held2", 32'(commit_store), 32'd1);
    nxt(); #1;
    check("store_pulse_end", 32'(commit_store), 32'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int k;
      logic [4:0] t;
      nxt();
      rst = ($urandom_range(499, 0) == 0);
      rdy = ($urandom_range(9, 0) != 0);
      if ($urandom_range(9, 0) < 6) begin
        k = $urandom_range(9, 0);
        disp((k == 1) ? 5'd0 : 5'($urandom_range(31, 1)), $urandom & ~32'h3, k == 0, k == 1,
             1'($urandom_range(1, 0)));
      end
      if ($urandom_range(9, 0) < 6) begin
        if (q.size() > 0 && $urandom_range(3, 0) != 0) t = q[$urandom_range(q.size() - 1, 0)].tag;
        else t = 5'($urandom_range(31, 0));
        cdb(t, $urandom, 1'($urandom_range(1, 0)), $urandom & ~32'h3);
      end
      if (q.size() > 0 && $urandom_range(1, 0) != 0) query_tag1 = q[$urandom_range(q.size() - 1, 0)].tag;
      else query_tag1 = 5'($urandom_range(31, 0));
      if (cdb_valid && $urandom_range(3, 0) == 0) query_tag2 = cdb_tag;
      else query_tag2 = 5'($urandom_range(DEPTH, 0));
    end
    nxt(); rst = 0;
    repeat (3) nxt();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
